// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC register, req/ack memory fetch, valid/ready hand-off with beq/jump redirect.
// Optional halt-opcode stop is enabled by defining HALT_DETECT_EN.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          PC_STEP  = 4
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instruction,
  output logic [31:0] pc_out,
  output logic        instr_valid,
  input  logic        instr_ready,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [31:0] jump_target,
  output logic [31:0] fetch_count,
  output logic        halted
);

`ifdef HALT_DETECT_EN
  typedef enum logic [1:0] {RESET, FETCH, HOLD, HALT} state_t;
`else
  typedef enum logic [1:0] {RESET, FETCH, HOLD} state_t;
`endif

  state_t      state;
  logic [31:0] pc;
  logic [31:0] next_pc;

  assign imem_addr = pc;
  assign pc_out    = pc;

  // Redirect targets are word-aligned on load; jump wins over branch.
  always_comb begin
    next_pc = pc + 32'(PC_STEP);
    if (jump)
      next_pc = {jump_target[31:2], 2'b00};
    else if (branch_taken)
      next_pc = {branch_target[31:2], 2'b00};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= RESET;
      pc          <= RESET_PC;
      instruction <= 32'h0;
      fetch_count <= 32'h0;
      imem_req    <= 1'b0;
      instr_valid <= 1'b0;
`ifdef HALT_DETECT_EN
      halted      <= 1'b0;
`endif
    end else begin
      case (state)
        RESET: begin
          state    <= FETCH;
          imem_req <= 1'b1;
        end
        FETCH: begin
          if (imem_ack) begin
            instruction <= imem_rdata;
            imem_req    <= 1'b0;
            instr_valid <= 1'b1;
            state       <= HOLD;
          end
        end
        HOLD: begin
          if (instr_ready) begin
            fetch_count <= fetch_count + 32'd1;
            instr_valid <= 1'b0;
`ifdef HALT_DETECT_EN
            if (instruction[31:26] == 6'h3f) begin
              halted <= 1'b1;
              state  <= HALT;
            end else
`endif
            begin
              pc       <= next_pc;
              imem_req <= 1'b1;
              state    <= FETCH;
            end
          end
        end
`ifdef HALT_DETECT_EN
        HALT: state <= HALT;
`endif
        default: begin
          state       <= RESET;
          imem_req    <= 1'b0;
          instr_valid <= 1'b0;
        end
      endcase
    end
  end

`ifndef HALT_DETECT_EN
  assign halted = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus randomized memory latency, backpressure and redirects,
// checked every cycle against a transaction-level model of the fetch/hold/accept rules.
module tb_fetch_unit;
  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instruction;
  logic [31:0] pc_out;
  logic        instr_valid;
  logic        instr_ready;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        jump;
  logic [31:0] jump_target;
  logic [31:0] fetch_count;
  logic        halted;

  fetch_unit #(.RESET_PC(RST_PC), .PC_STEP(4)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .instruction(instruction), .pc_out(pc_out), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .branch_taken(branch_taken), .branch_target(branch_target), .jump(jump), .jump_target(jump_target),
    .fetch_count(fetch_count), .halted(halted)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Transaction-level view: a request is outstanding, an instruction is held, or fetch has stopped.
  bit          m_starting, m_busy, m_have, m_halt;
  logic [31:0] m_pc, m_instr, m_count;

  function automatic bit halt_enabled();
`ifdef HALT_DETECT_EN
    return 1'b1;
`else
    return 1'b0;
`endif
  endfunction

  task automatic model_reset();
    m_starting = 1; m_busy = 0; m_have = 0; m_halt = 0;
    m_pc = RST_PC; m_instr = 32'h0; m_count = 32'h0;
  endtask

  task automatic model_edge();
    if (m_starting) begin
      m_starting = 0;
      m_busy = 1;
    end else if (m_busy) begin
      if (imem_ack) begin
        m_instr = imem_rdata;
        m_busy = 0;
        m_have = 1;
      end
    end else if (m_have && instr_ready) begin
      m_count = m_count + 1;
      m_have = 0;
      if (halt_enabled() && m_instr[31:26] == 6'h3f) m_halt = 1;
      else begin
        if (jump)              m_pc = jump_target & 32'hFFFF_FFFC;
        else if (branch_taken) m_pc = branch_target & 32'hFFFF_FFFC;
        else                   m_pc = m_pc + 32'd4;
        m_busy = 1;
      end
    end
  endtask

  task automatic compare_all();
    check("imem_req", {31'h0, imem_req}, {31'h0, m_busy});
    check("imem_addr", imem_addr, m_pc);
    check("pc_out", pc_out, m_pc);
    check("instr_valid", {31'h0, instr_valid}, {31'h0, m_have});
    check("instruction", instruction, m_instr);
    check("fetch_count", fetch_count, m_count);
    check("halted", {31'h0, halted}, {31'h0, m_halt});
  endtask

  // Called at a negedge: drive inputs, let one rising edge happen, check at the next negedge.
  task automatic cycle(input logic a, input logic [31:0] rd, input logic rdy, input logic br,
                       input logic [31:0] bt, input logic j, input logic [31:0] jt);
    imem_ack = a; imem_rdata = rd; instr_ready = rdy;
    branch_taken = br; branch_target = bt; jump = j; jump_target = jt;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare_all();
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cycle(1'b0, NOP, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
  endtask

  task automatic do_reset();
    #2;
    rst = 1'b1;
    imem_ack = 0; instr_ready = 0; branch_taken = 0; jump = 0;
    model_reset();
    #1 compare_all();
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Zero-wait fetch of rd, then accept it with the given redirect inputs.
  task automatic fetch_accept(input logic [31:0] rd, input logic br, input logic [31:0] bt,
                              input logic j, input logic [31:0] jt);
    for (int n = 0; n < 8 && !m_busy; n++) idle(1);
    check("fetch_wait_req", {31'h0, imem_req}, 32'h1);
    cycle(1'b1, rd, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    cycle(1'b0, NOP, 1'b1, br, bt, j, jt);
  endtask

  logic [31:0] addrs[$];
  logic [31:0] cnt0;
  logic [31:0] held;

  initial begin
    rst = 1'b1;
    imem_ack = 0; imem_rdata = 0; instr_ready = 0;
    branch_taken = 0; branch_target = 0; jump = 0; jump_target = 0;
    model_reset();
    #3 compare_all();
    @(negedge clk);
    rst = 1'b0;

    // Zero-wait memory, always-ready consumer: addresses 0,4,8 and three accepts.
    for (int k = 0; k < 7; k++) begin
      cycle(1'b1, 32'h1000 + k, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
      if (imem_req && addrs.size() < 3) addrs.push_back(imem_addr);
    end
    check("t1_count", fetch_count, 32'd3);
    check("t1_naddr", addrs.size(), 32'd3);
    for (int k = 0; k < addrs.size(); k++) check("t1_addr", addrs[k], 32'(k * 4));

    // Slow memory and stalled consumer: everything holds, one increment.
    cnt0 = m_count;
    idle(3);
    cycle(1'b1, 32'hCAFE_0001, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    held = instruction;
    for (int k = 0; k < 4; k++) cycle(1'b1, $urandom, 1'b0, 1'b1, 32'h200, 1'b1, 32'h300);
    check("t2_held", instruction, 32'hCAFE_0001);
    check("t2_held_stable", instruction, held);
    cycle(1'b0, NOP, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    check("t2_count", fetch_count, cnt0 + 32'd1);

    // Branch to an unaligned target from pc 0x10.
    fetch_accept(NOP, 1'b0, 32'h0, 1'b1, 32'h10);
    check("t3_pc", imem_addr, 32'h10);
    fetch_accept(NOP, 1'b1, 32'h43, 1'b0, 32'h0);
    check("t3_branch", imem_addr, 32'h40);

    // Jump wins over branch.
    fetch_accept(NOP, 1'b1, 32'h200, 1'b1, 32'h100);
    check("t4_jump_prio", imem_addr, 32'h100);

    // PC wraps at the top of the address space.
    fetch_accept(NOP, 1'b0, 32'h0, 1'b1, 32'hFFFF_FFFC);
    fetch_accept(NOP, 1'b0, 32'h0, 1'b0, 32'h0);
    check("t5_wrap", imem_addr, 32'h0);

    // Reset while a request is outstanding.
    idle(2);
    do_reset();
    check("rst_mid_req", {31'h0, imem_req}, 32'h0);
    idle(1);
    check("refetch_addr", imem_addr, RST_PC);

`ifdef HALT_DETECT_EN
    fetch_accept(NOP, 1'b0, 32'h0, 1'b1, 32'h8);
    fetch_accept(32'hFC00_0000, 1'b0, 32'h0, 1'b1, 32'h500);
    check("t6_halted", {31'h0, halted}, 32'h1);
    check("t6_pc", pc_out, 32'h8);
    for (int k = 0; k < 5; k++) cycle(1'b1, NOP, 1'b1, 1'b0, 32'h0, 1'b1, 32'h40);
    check("t6_req_off", {31'h0, imem_req}, 32'h0);
    do_reset();
    idle(1);
    check("t6_refetch", imem_addr, RST_PC);
`endif

    // Random latency, backpressure, redirects and occasional resets.
    for (int k = 0; k < 1500; k++) begin
      if ($urandom_range(0, 199) == 0 || (m_halt && $urandom_range(0, 15) == 0)) do_reset();
      else cycle($urandom_range(0, 2) == 0, $urandom, $urandom_range(0, 1) == 1,
                 $urandom_range(0, 3) == 0,
                 $urandom_range(0, 7) == 0 ? 32'hFFFF_FFF0 | 32'($urandom_range(0, 15)) : $urandom,
                 $urandom_range(0, 4) == 0, $urandom);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
